// File: rtl/pwm_dt_pkg.sv
// pwm_dt_pkg
// Shared definitions for the dead-time PWM block: channel FSM state encoding,
// register byte offsets relative to the block base address, and CONTROL
// register field positions.
package pwm_dt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOW_ON,
    DT_RISE,
    HIGH_ON,
    DT_FALL
  } dt_state_e;

  localparam logic [31:0] REG_CONTROL_OFS  = 32'h0;
  localparam logic [31:0] REG_DEADTIME_OFS = 32'h4;

  localparam int NUM_CH  = 3;
  localparam int EN_LSB  = 0;
  localparam int POL_LSB = 3;
  localparam int BRK_BIT = 8;

endpackage

// File: rtl/wb_bus.sv
// wb_bus
// Classic single-cycle Wishbone register bus (32-bit data, byte selects).
//   master modport: drives cyc/stb/we/adr/dat_w/sel, receives dat_r/ack/err
//   slave  modport: receives the request, drives dat_r/ack/err
interface wb_bus;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;

  modport master (
    output cyc, stb, we, adr, dat_w, sel,
    input  dat_r, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel,
    output dat_r, ack, err
  );
endinterface

// File: rtl/pwm_dt_channel.sv
// pwm_dt_channel
// One complementary output channel: turns a single PWM input into a high/low
// drive pair with a dead-time gap on every transition.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   en          channel enable; low forces IDLE on the same edge
//   force_idle  external abort (fault break); forces IDLE on the same edge
//   pwm         PWM request, sampled every rising edge
//   dt_rise     cycles of both-off gap before the high side turns on
//   dt_fall     cycles of both-off gap before the low side turns on
//   hi, lo      registered Moore decode of the state (never both 1)
module pwm_dt_channel
  import pwm_dt_pkg::*;
#(
  parameter int DtWidth = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               force_idle,
  input  logic               pwm,
  input  logic [DtWidth-1:0] dt_rise,
  input  logic [DtWidth-1:0] dt_fall,
  output logic               hi,
  output logic               lo
);

  localparam logic [DtWidth-1:0] CNT_ONE = DtWidth'(1);

  dt_state_e          state;
  logic [DtWidth-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en || force_idle) begin
      // Drive pins off on the same edge the channel is stopped so a fault or
      // disable never leaves a switch conducting for an extra cycle.
      state <= IDLE;
      cnt   <= '0;
      hi    <= 1'b0;
      lo    <= 1'b0;
    end else begin
      hi <= (state == HIGH_ON);
      lo <= (state == LOW_ON);
      case (state)
        IDLE, LOW_ON: begin
          if (pwm) begin
            if (dt_rise == '0) begin
              state <= HIGH_ON;
            end else begin
              state <= DT_RISE;
              cnt   <= dt_rise;
            end
          end else begin
            state <= LOW_ON;
          end
        end
        DT_RISE: begin
          // A pulse shorter than the gap is swallowed: fall back to low side.
          if (!pwm) begin
            state <= LOW_ON;
          end else if (cnt == CNT_ONE) begin
            state <= HIGH_ON;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        HIGH_ON: begin
          if (!pwm) begin
            if (dt_fall == '0) begin
              state <= LOW_ON;
            end else begin
              state <= DT_FALL;
              cnt   <= dt_fall;
            end
          end
        end
        DT_FALL: begin
          if (pwm) begin
            state <= HIGH_ON;
          end else if (cnt == CNT_ONE) begin
            state <= LOW_ON;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pwm_deadtime.sv
// pwm_deadtime
// Takes the three timer compare outputs and drives a complementary high/low
// pin pair per channel with programmable dead time, so both sides of a
// half-bridge are never on together. Wishbone slave for configuration.
// Ports:
//   clk_in      system clock (single domain)
//   reset_in    synchronous reset, active-high
//   pwm_in      timer compare outputs, one per channel
//   pwm_hi_out  high-side pin per channel (after polarity)
//   pwm_lo_out  low-side pin per channel (after polarity)
//   break_in    asynchronous fault input (only with PWM_DT_BREAK_EN)
//   bus_slave   Wishbone register port
// Registers (byte address):
//   BaseAddr+0  CONTROL  [2:0] EN, [5:3] POL, [8] BRK (W1C, break build only)
//   BaseAddr+4  DEADTIME [DtWidth-1:0] DT_RISE, [DtWidth+7:8] DT_FALL
// Build option: define PWM_DT_BREAK_EN to add the fault-break input.
module pwm_deadtime
  import pwm_dt_pkg::*;
#(
  parameter logic [31:0] BaseAddr = 32'h4040,
  parameter int          DtWidth  = 8
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic [2:0] pwm_in,
  output logic [2:0] pwm_hi_out,
  output logic [2:0] pwm_lo_out,
`ifdef PWM_DT_BREAK_EN
  input  logic       break_in,
`endif
  wb_bus.slave       bus_slave
);

  localparam logic [31:0] CTRL_ADDR = BaseAddr + REG_CONTROL_OFS;
  localparam logic [31:0] DT_ADDR   = BaseAddr + REG_DEADTIME_OFS;

  logic [NUM_CH-1:0]  en_q;
  logic [NUM_CH-1:0]  pol_q;
  logic [DtWidth-1:0] dt_rise_q;
  logic [DtWidth-1:0] dt_fall_q;
  logic [NUM_CH-1:0]  hi;
  logic [NUM_CH-1:0]  lo;
  logic               force_idle;

  logic access;
  logic wr;
  logic hit_ctrl;
  logic hit_dt;

  assign access   = bus_slave.cyc & bus_slave.stb;
  assign wr       = access & bus_slave.we;
  assign hit_ctrl = (bus_slave.adr[31:2] == CTRL_ADDR[31:2]);
  assign hit_dt   = (bus_slave.adr[31:2] == DT_ADDR[31:2]);

  // Byte lanes not backed by register bits are simply dropped.
  logic unused_bus;
  assign unused_bus = ^{bus_slave.adr[1:0], bus_slave.dat_w, bus_slave.sel[3:2]};

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      en_q      <= '0;
      pol_q     <= '0;
      dt_rise_q <= '0;
      dt_fall_q <= '0;
    end else if (wr) begin
      if (hit_ctrl && bus_slave.sel[0]) begin
        en_q  <= bus_slave.dat_w[EN_LSB +: NUM_CH];
        pol_q <= bus_slave.dat_w[POL_LSB +: NUM_CH];
      end
      if (hit_dt && bus_slave.sel[0]) dt_rise_q <= bus_slave.dat_w[DtWidth-1:0];
      if (hit_dt && bus_slave.sel[1]) dt_fall_q <= bus_slave.dat_w[8 +: DtWidth];
    end
  end

`ifdef PWM_DT_BREAK_EN
  logic brk_meta;
  logic brk_sync;
  logic brk_q;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      brk_meta <= 1'b0;
      brk_sync <= 1'b0;
      brk_q    <= 1'b0;
    end else begin
      brk_meta <= break_in;
      brk_sync <= brk_meta;
      // Set wins over the W1C clear while the fault is still present.
      if (brk_sync) begin
        brk_q <= 1'b1;
      end else if (wr && hit_ctrl && bus_slave.sel[1] && bus_slave.dat_w[BRK_BIT]) begin
        brk_q <= 1'b0;
      end
    end
  end

  // The synchronized level joins in directly so channels drop on the very
  // edge that latches BRK.
  assign force_idle = brk_q | brk_sync;
`else
  logic brk_q;
  assign brk_q      = 1'b0;
  assign force_idle = 1'b0;
`endif

  always_comb begin
    bus_slave.dat_r = '0;
    if (hit_ctrl) begin
      bus_slave.dat_r[EN_LSB +: NUM_CH]  = en_q;
      bus_slave.dat_r[POL_LSB +: NUM_CH] = pol_q;
      bus_slave.dat_r[BRK_BIT]           = brk_q;
    end else if (hit_dt) begin
      bus_slave.dat_r[DtWidth-1:0] = dt_rise_q;
      bus_slave.dat_r[8 +: DtWidth] = dt_fall_q;
    end
  end

  assign bus_slave.ack = access;
  assign bus_slave.err = 1'b0;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    pwm_dt_channel #(
      .DtWidth(DtWidth)
    ) u_channel (
      .clk       (clk_in),
      .rst       (reset_in),
      .en        (en_q[ch]),
      .force_idle(force_idle),
      .pwm       (pwm_in[ch]),
      .dt_rise   (dt_rise_q),
      .dt_fall   (dt_fall_q),
      .hi        (hi[ch]),
      .lo        (lo[ch])
    );
  end

  // Polarity inverts both pins, so a stopped channel rests at POL.
  assign pwm_hi_out = hi ^ pol_q;
  assign pwm_lo_out = lo ^ pol_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
module tb_pwm_deadtime;

  localparam logic [31:0] BASE = 32'h4040;
  localparam logic [31:0] CTRL = BASE;
  localparam logic [31:0] DTR  = BASE + 32'h4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] pwm_in;
  logic [2:0] hi_o;
  logic [2:0] lo_o;
`ifdef PWM_DT_BREAK_EN
  logic       brk_in;
`endif

  wb_bus bus();

  pwm_deadtime #(
    .BaseAddr(BASE),
    .DtWidth (8)
  ) dut (
    .clk_in    (clk),
    .reset_in  (rst),
    .pwm_in    (pwm_in),
    .pwm_hi_out(hi_o),
    .pwm_lo_out(lo_o),
`ifdef PWM_DT_BREAK_EN
    .break_in  (brk_in),
`endif
    .bus_slave (bus)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct {
    int         cyc;
    logic [2:0] hi;
    logic [2:0] lo;
    string      name;
  } pin_exp_t;

  typedef struct {
    logic [31:0] data;
    string       name;
  } rd_exp_t;

  pin_exp_t pin_q[$];
  rd_exp_t  rd_q[$];
  int       n_cmp = 0;
  int       n_bad = 0;
  logic [2:0] pol_m = 3'b000;

  // Monitor: compares pins against scheduled expectations, bus reads against
  // queued read data, and the no-overlap invariant every cycle.
  pin_exp_t pe;
  rd_exp_t  re;
  always @(negedge clk) begin
    if (cyc_n > 2) begin
      n_cmp++;
      if (((hi_o ^ pol_m) & (lo_o ^ pol_m)) != 3'b000) begin
        n_bad++;
        $display("FAIL overlap cyc=%0d hi=%b lo=%b pol=%b (hi&lo must be 0)", cyc_n, hi_o, lo_o, pol_m);
      end
    end
    while (pin_q.size() > 0 && pin_q[0].cyc <= cyc_n) begin
      pe = pin_q.pop_front();
      n_cmp++;
      if (pe.cyc != cyc_n || hi_o !== pe.hi || lo_o !== pe.lo) begin
        n_bad++;
        $display("FAIL %s cyc=%0d/%0d got hi=%b lo=%b expected hi=%b lo=%b",
                 pe.name, cyc_n, pe.cyc, hi_o, lo_o, pe.hi, pe.lo);
      end
    end
    if (bus.cyc && bus.stb && !bus.we) begin
      n_cmp++;
      if (rd_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_read got %h expected no read", bus.dat_r);
      end else begin
        re = rd_q.pop_front();
        if (bus.dat_r !== re.data || bus.ack !== 1'b1) begin
          n_bad++;
          $display("FAIL %s got dat=%h ack=%b expected dat=%h ack=1", re.name, bus.dat_r, bus.ack, re.data);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1;
    bus.adr = a; bus.dat_w = d; bus.sel = s;
    @(posedge clk); #1;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] a, input logic [31:0] exp_d, input string name);
    rd_q.push_back('{exp_d, name});
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0;
    bus.adr = a; bus.sel = 4'hF;
    @(posedge clk); #1;
    bus.cyc = 1'b0; bus.stb = 1'b0;
  endtask

  task automatic expect_at(input int ofs, input logic [2:0] h, input logic [2:0] l, input string name);
    pin_q.push_back('{cyc_n + ofs, h, l, name});
  endtask

  initial begin
    rst = 1'b1;
    pwm_in = 3'b000;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    bus.adr = '0; bus.dat_w = '0; bus.sel = '0;
`ifdef PWM_DT_BREAK_EN
    brk_in = 1'b0;
`endif
    tick(4);
    expect_at(0, 3'b000, 3'b000, "reset_pins");
    tick(1);
    rst = 1'b0;
    wb_read(CTRL, 32'h0, "reset_ctrl");
    wb_read(DTR, 32'h0, "reset_dt");

    // Rise 3 / fall 2 on channel 0
    wb_write(DTR, 32'h0000_0203, 4'b0011);
    wb_write(CTRL, 32'h1, 4'b0001);
    tick(3);
    expect_at(0, 3'b000, 3'b001, "t1_low_on");
    pwm_in = 3'b001;
    expect_at(1, 3'b000, 3'b001, "t1_rise_lo_held");
    for (int i = 2; i <= 4; i++) expect_at(i, 3'b000, 3'b000, "t1_rise_gap");
    expect_at(5, 3'b001, 3'b000, "t1_high_on");
    tick(6);
    pwm_in = 3'b000;
    expect_at(1, 3'b001, 3'b000, "t1_fall_hi_held");
    expect_at(2, 3'b000, 3'b000, "t1_fall_gap");
    expect_at(3, 3'b000, 3'b000, "t1_fall_gap");
    expect_at(4, 3'b000, 3'b001, "t1_low_again");
    tick(5);

    // Rise 5 (byte 0 only, fall stays 2), 2-cycle pulse is swallowed
    wb_write(DTR, 32'h0000_0005, 4'b0001);
    tick(1);
    expect_at(0, 3'b000, 3'b001, "t2_low_on");
    pwm_in = 3'b001;
    expect_at(1, 3'b000, 3'b001, "t2_lo_held");
    tick(2);
    pwm_in = 3'b000;
    expect_at(0, 3'b000, 3'b000, "t2_gap");
    expect_at(1, 3'b000, 3'b000, "t2_gap");
    for (int i = 2; i <= 6; i++) expect_at(i, 3'b000, 3'b001, "t2_swallowed");
    tick(7);
    wb_read(DTR, 32'h0000_0205, "t2_dt_readback");

    // Zero dead time: straight swap
    wb_write(DTR, 32'h0, 4'b0011);
    tick(1);
    expect_at(0, 3'b000, 3'b001, "t3_low_on");
    pwm_in = 3'b001;
    expect_at(1, 3'b000, 3'b001, "t3_lo_held");
    expect_at(2, 3'b001, 3'b000, "t3_swap_hi");
    expect_at(3, 3'b001, 3'b000, "t3_hi_held");
    tick(3);
    pwm_in = 3'b000;
    expect_at(1, 3'b001, 3'b000, "t3_hi_held2");
    expect_at(2, 3'b000, 3'b001, "t3_swap_lo");
    tick(3);

    // Polarity on channel 1 only, channel 0/2 disabled
    wb_write(CTRL, 32'h12, 4'b0001);
    pol_m = 3'b010;
    tick(3);
    expect_at(0, 3'b010, 3'b000, "t4_pol_low_on");
    wb_read(CTRL, 32'h12, "t4_ctrl_read");
    wb_write(CTRL, 32'h0000_01FF, 4'b0010);
    wb_read(CTRL, 32'h12, "t4_sel_mask");
    wb_write(BASE + 32'h8, 32'hFFFF_FFFF, 4'hF);
    wb_read(BASE + 32'h8, 32'h0, "t4_unmapped_read");
    wb_read(CTRL, 32'h12, "t4_unmapped_write");
    pwm_in = 3'b111;
    expect_at(1, 3'b010, 3'b000, "t4_before_swap");
    expect_at(2, 3'b000, 3'b010, "t4_pol_high_on");
    tick(3);
    pwm_in = 3'b000;
    expect_at(2, 3'b010, 3'b000, "t4_pol_back_low");
    tick(3);

    // Disable during rise countdown aborts; re-enable with pwm low
    wb_write(DTR, 32'h0000_0205, 4'b0011);
    wb_write(CTRL, 32'h1, 4'b0001);
    pol_m = 3'b000;
    tick(3);
    expect_at(0, 3'b000, 3'b001, "t5_low_on");
    pwm_in = 3'b001;
    tick(1);
    wb_write(CTRL, 32'h0, 4'b0001);
    for (int i = 0; i <= 8; i++) expect_at(i, 3'b000, 3'b000, "t5_disabled");
    tick(9);
    pwm_in = 3'b000;
    wb_write(CTRL, 32'h1, 4'b0001);
    expect_at(0, 3'b000, 3'b000, "t5_reen_idle");
    expect_at(1, 3'b000, 3'b000, "t5_reen_idle");
    expect_at(2, 3'b000, 3'b001, "t5_reen_low_on");
    tick(3);

    // Reset in the middle of operation
    rst = 1'b1;
    tick(1);
    expect_at(0, 3'b000, 3'b000, "t6_rst_pins");
    rst = 1'b0;
    wb_read(CTRL, 32'h0, "t6_rst_ctrl");
    wb_read(DTR, 32'h0, "t6_rst_dt");

`ifdef PWM_DT_BREAK_EN
    wb_write(CTRL, 32'h1, 4'b0001);
    pwm_in = 3'b001;
    tick(3);
    expect_at(0, 3'b001, 3'b000, "t7_high_on");
    brk_in = 1'b1;
    tick(2);
    brk_in = 1'b0;
    expect_at(0, 3'b001, 3'b000, "t7_sync_delay");
    expect_at(1, 3'b000, 3'b000, "t7_break_off");
    expect_at(2, 3'b000, 3'b000, "t7_break_hold");
    tick(3);
    wb_read(CTRL, 32'h101, "t7_brk_set");
    wb_write(CTRL, 32'h100, 4'b0010);
    expect_at(0, 3'b000, 3'b000, "t7_clear_idle");
    expect_at(1, 3'b000, 3'b000, "t7_clear_idle");
    expect_at(2, 3'b001, 3'b000, "t7_resume_high");
    tick(3);
    wb_read(CTRL, 32'h1, "t7_brk_cleared");
`endif

    pwm_in = 3'b000;
    for (int i = 0; i < 50 && (pin_q.size() > 0 || rd_q.size() > 0); i++) tick(1);
    if (pin_q.size() > 0 || rd_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain pending=%0d expected 0", pin_q.size() + rd_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
